// File: rtl/exec_pkg.sv
// Shared opcode encoding and default sizing for the execution pipeline.
package exec_pkg;

    localparam int DW_DEFAULT   = 16;
    localparam int NREG_DEFAULT = 16;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_AND   = 4'd3,
        OP_OR    = 4'd4,
        OP_XOR   = 4'd5,
        OP_SLL   = 4'd6,
        OP_SRL   = 4'd7,
        OP_SRA   = 4'd8,
        OP_ADDI  = 4'd9,
        OP_MOV   = 4'd10,
        OP_SLT   = 4'd11,
        OP_MUL   = 4'd12,
        OP_ILL13 = 4'd13,
        OP_ILL14 = 4'd14,
        OP_ILL15 = 4'd15
    } op_e;

    // Opcodes 13..15 are reserved; they flow through as bubbles.
    function automatic logic op_legal(input op_e op);
        return op <= OP_MUL;
    endfunction

    // Only legal, non-NOP opcodes produce a writeback.
    function automatic logic op_writes(input op_e op);
        return (op != OP_NOP) && (op <= OP_MUL);
    endfunction

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, DW cycles
// per operation, low DW bits of the product presented alongside done.
module seq_mul #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          done,
    output logic [DW-1:0] product
);

    localparam int CW = $clog2(DW);

    logic          running;
    logic [CW-1:0] cnt;
    logic [DW-1:0] mcand;
    logic [DW-1:0] mplier;
    logic [DW-1:0] acc;

    // Accumulator plus this step's partial product; the final step's sum is the result.
    always_comb begin
        product = acc + (mplier[0] ? mcand : '0);
    end

    assign done = running && (cnt == CW'(DW - 1));

    // Load operands on start, then consume one multiplier bit per cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            running <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            mcand   <= a;
            mplier  <= b;
            acc     <= '0;
        end else if (running) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_pipeline.sv
// Three-stage in-order execution pipeline (decode, execute, writeback) with
// full forwarding into the S1->S2 transfer and an iterative multiplier in S2.
module exec_pipeline
    import exec_pkg::*;
#(
    parameter  int DW   = DW_DEFAULT,
    parameter  int NREG = NREG_DEFAULT,
    localparam int RW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [RW-1:0] in_rd,
    input  logic [RW-1:0] in_rs1,
    input  logic [RW-1:0] in_rs2,
    input  logic [DW-1:0] in_imm,
    output logic          wb_valid,
    output logic [RW-1:0] wb_rd,
    output logic [DW-1:0] wb_data,
    input  logic [RW-1:0] dbg_raddr,
    output logic [DW-1:0] dbg_rdata,
    output logic          busy,
    output logic          err
);

    localparam int SW = $clog2(DW);

    logic [DW-1:0] rf [NREG];

    logic          s1_valid;
    op_e           s1_op;
    logic [RW-1:0] s1_rd, s1_rs1, s1_rs2;
    logic [DW-1:0] s1_imm;

    logic          s2_valid;
    op_e           s2_op;
    logic [RW-1:0] s2_rd;
    logic [DW-1:0] s2_a, s2_b;

    logic          s3_valid, s3_wr;
    logic [RW-1:0] s3_rd;
    logic [DW-1:0] s3_data;

    logic          err_q;
    logic          s2_done, s1_adv, s1_ready;
    logic          s2_fwd_ok, s3_fwd_ok;
    logic          mul_start, mul_done;
    logic [DW-1:0] mul_product, alu_result, opnd_a, opnd_b;
    logic [SW-1:0] shamt;

    assign s2_done  = s2_valid && ((s2_op != OP_MUL) || mul_done);
    assign s1_adv   = !s2_valid || s2_done;
    assign s1_ready = !s1_valid || s1_adv;

    assign mul_start = s1_valid && s1_adv && (s1_op == OP_MUL);

    seq_mul #(.DW(DW)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (opnd_a),
        .b       (opnd_b),
        .done    (mul_done),
        .product (mul_product)
    );

    assign shamt = s2_b[SW-1:0];

    // Execute-stage result for the instruction currently in S2.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        alu_result = '0;
        case (s2_op)
            OP_ADD, OP_ADDI: alu_result = s2_a + s2_b;
            OP_SUB:          alu_result = s2_a - s2_b;
            OP_AND:          alu_result = s2_a & s2_b;
            OP_OR:           alu_result = s2_a | s2_b;
            OP_XOR:          alu_result = s2_a ^ s2_b;
            OP_SLL:          alu_result = s2_a << shamt;
            OP_SRL:          alu_result = s2_a >> shamt;
            OP_SRA:          alu_result = $unsigned($signed(s2_a) >>> shamt);
            OP_MOV:          alu_result = s2_b;
            OP_SLT:          alu_result = {{(DW-1){1'b0}}, ($signed(s2_a) < $signed(s2_b))};
            OP_MUL:          alu_result = mul_product;
            default:         alu_result = '0;
        endcase
    end

    // Bubbles and r0 destinations never act as forwarding sources.
    assign s2_fwd_ok = s2_done && op_writes(s2_op) && (s2_rd != '0);
    assign s3_fwd_ok = s3_valid && s3_wr && (s3_rd != '0);

    function automatic logic [DW-1:0] read_operand(input logic [RW-1:0] idx);
        if (s2_fwd_ok && (s2_rd == idx)) begin
            return alu_result;
        end else if (s3_fwd_ok && (s3_rd == idx)) begin
            return s3_data;
        end
        return rf[idx];
    endfunction

    // Operand resolution for the S1->S2 transfer; ADDI/MOV take the immediate as b.
    always_comb begin
        opnd_a = read_operand(s1_rs1);
        opnd_b = read_operand(s1_rs2);
        if ((s1_op == OP_ADDI) || (s1_op == OP_MOV)) begin
            opnd_b = s1_imm;
        end
    end

    // Stage registers and the sticky illegal-opcode flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_NOP;
            s1_rd    <= '0;
            s1_rs1   <= '0;
            s1_rs2   <= '0;
            s1_imm   <= '0;
            s2_valid <= 1'b0;
            s2_op    <= OP_NOP;
            s2_rd    <= '0;
            s2_a     <= '0;
            s2_b     <= '0;
            s3_valid <= 1'b0;
            s3_wr    <= 1'b0;
            s3_rd    <= '0;
            s3_data  <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates let every stage read the pre-edge value of the stage ahead of it.
            if (s1_ready) begin
                s1_valid <= in_valid;
                s1_op    <= op_e'(in_op);
                s1_rd    <= in_rd;
                s1_rs1   <= in_rs1;
                s1_rs2   <= in_rs2;
                s1_imm   <= in_imm;
            end
            if (s1_adv) begin
                s2_valid <= s1_valid;
                s2_op    <= s1_op;
                s2_rd    <= s1_rd;
                s2_a     <= opnd_a;
                s2_b     <= opnd_b;
            end
            s3_valid <= s2_done;
            s3_wr    <= s2_done && op_writes(s2_op);
            s3_rd    <= s2_rd;
            s3_data  <= alu_result;
            if (s1_valid && !op_legal(s1_op)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Register file: written from S3 at the end of its writeback cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the file is built from flops rather than a RAM macro, so clearing it in reset is legal and cheap to reason about.
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_valid && (s3_rd != '0)) begin
            rf[s3_rd] <= s3_data;
        end
    end

    assign dbg_rdata = rf[dbg_raddr];

    // Outputs are forced quiet while reset is held, before the first reset edge lands.
    assign in_ready = reset && s1_ready;
    assign wb_valid = reset && s3_valid && s3_wr;
    assign wb_rd    = reset ? s3_rd : '0;
    assign wb_data  = reset ? s3_data : '0;
    assign busy     = reset && (s1_valid || s2_valid || s3_valid);
    assign err      = reset && err_q;

endmodule

// File: tb/tb_exec_pipeline.sv
// Self-checking bench for exec_pipeline: a table of single-cycle ops with
// expected results, plus hand sequences for MUL stall, illegal op and reset.
module tb_exec_pipeline;
    import exec_pkg::*;

    localparam int DW   = 16;
    localparam int NREG = 16;
    localparam int RW   = 4;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [RW-1:0] in_rd, in_rs1, in_rs2;
    logic [DW-1:0] in_imm;
    logic          wb_valid;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic [RW-1:0] dbg_raddr;
    logic [DW-1:0] dbg_rdata;
    logic          busy;
    logic          err;

    exec_pipeline #(.DW(DW), .NREG(NREG)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata),
        .busy      (busy),
        .err       (err)
    );

    typedef struct {
        logic [3:0]    op;
        logic [RW-1:0] rd, rs1, rs2;
        logic [DW-1:0] imm;
        logic [DW-1:0] exp;
    } vec_t;

    typedef struct {
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
        int            cyc;
    } wb_t;

    vec_t vecs[$];
    wb_t  sb[$];
    wb_t  obs[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every writeback the DUT produces, tagged with its cycle.
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            obs.push_back('{wb_rd, wb_data, cyc});
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                           input logic [RW-1:0] rs2, input logic [DW-1:0] imm, input logic [DW-1:0] exp);
        vecs.push_back('{op, rd, rs1, rs2, imm, exp});
    endtask

    // Present one instruction at a negedge and return at the negedge after it is taken.
    task automatic send(input logic [3:0] op, input logic [RW-1:0] rd, input logic [RW-1:0] rs1,
                        input logic [RW-1:0] rs2, input logic [DW-1:0] imm, input bit wr,
                        input logic [DW-1:0] exp, input int lat, output int stalls);
        stalls   = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        #1;
        while (in_ready !== 1'b1 && stalls < 100) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (stalls < 100 && wr) begin
            sb.push_back('{rd, exp, cyc + lat});
        end
    endtask

    // Wait for the pipeline to empty, then match observed writebacks against the scoreboard.
    task automatic drain(input string tag);
        int  n = 0;
        wb_t e, o;
        while ((busy === 1'b1 || obs.size() < sb.size()) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check({tag, "_drain_timeout"}, 32'(n >= 200), 32'd0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (obs.size() == 0) begin
                check({tag, "_wb_missing"}, 32'd0, 32'd1);
            end else begin
                o = obs.pop_front();
                check($sformatf("%s_wb_rd(exp r%0d)", tag, e.rd), 32'(o.rd), 32'(e.rd));
                check($sformatf("%s_wb_data(r%0d)", tag, e.rd), 32'(o.data), 32'(e.data));
                check($sformatf("%s_wb_cycle(r%0d)", tag, e.rd), 32'(o.cyc), 32'(e.cyc));
            end
        end
        check({tag, "_extra_wb_count"}, 32'(obs.size()), 32'd0);
        obs.delete();
    endtask

    task automatic check_reg(input logic [RW-1:0] r, input logic [DW-1:0] exp);
        dbg_raddr = r;
        #1;
        check($sformatf("dbg_r%0d", r), 32'(dbg_rdata), 32'(exp));
    endtask

    initial begin
        int st;
        int low;

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 4'd0;
        in_rd     = '0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_imm    = '0;
        dbg_raddr = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_wb_valid", 32'(wb_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_wb_data", 32'(wb_data), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("in_ready_after_reset", 32'(in_ready), 32'd1);
        for (int i = 0; i < NREG; i++) check_reg(RW'(i), '0);
        @(negedge clk);

        // Dependent single-cycle stream: forwarding from S2, S3 and the file, no stalls.
        add_vec(OP_ADDI, 4'd1,  4'd0,  4'd0,  16'd5,    16'h0005);
        add_vec(OP_ADDI, 4'd2,  4'd0,  4'd0,  16'd7,    16'h0007);
        add_vec(OP_ADD,  4'd3,  4'd1,  4'd2,  16'd0,    16'h000C);
        add_vec(OP_SUB,  4'd4,  4'd1,  4'd2,  16'd0,    16'hFFFE);
        add_vec(OP_AND,  4'd5,  4'd3,  4'd4,  16'd0,    16'h000C);
        add_vec(OP_OR,   4'd6,  4'd1,  4'd2,  16'd0,    16'h0007);
        add_vec(OP_XOR,  4'd7,  4'd1,  4'd2,  16'd0,    16'h0002);
        add_vec(OP_SLL,  4'd8,  4'd3,  4'd1,  16'd0,    16'h0180);
        add_vec(OP_SRL,  4'd9,  4'd4,  4'd1,  16'd0,    16'h07FF);
        add_vec(OP_SRA,  4'd10, 4'd4,  4'd1,  16'd0,    16'hFFFF);
        add_vec(OP_MOV,  4'd4,  4'd0,  4'd0,  16'hFFFF, 16'hFFFF);
        add_vec(OP_ADDI, 4'd4,  4'd4,  4'd0,  16'd1,    16'h0000);
        add_vec(OP_MOV,  4'd11, 4'd0,  4'd0,  16'h8000, 16'h8000);
        add_vec(OP_MOV,  4'd6,  4'd0,  4'd0,  16'd3,    16'h0003);
        add_vec(OP_SRA,  4'd5,  4'd11, 4'd6,  16'd0,    16'hF000);
        add_vec(OP_MOV,  4'd12, 4'd0,  4'd0,  16'd1,    16'h0001);
        add_vec(OP_SLT,  4'd13, 4'd11, 4'd12, 16'd0,    16'h0001);
        add_vec(OP_SLT,  4'd14, 4'd12, 4'd11, 16'd0,    16'h0000);
        add_vec(OP_MOV,  4'd2,  4'd0,  4'd0,  16'h0011, 16'h0011);
        add_vec(OP_SLL,  4'd15, 4'd12, 4'd2,  16'd0,    16'h0002);
        add_vec(OP_ADDI, 4'd0,  4'd0,  4'd0,  16'd9,    16'h0009);
        add_vec(OP_ADD,  4'd1,  4'd0,  4'd0,  16'd0,    16'h0000);

        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 1'b1, vecs[i].exp, 2, st);
            check($sformatf("vec%0d_issue_stall", i), 32'(st), 32'd0);
        end
        drain("table");
        check_reg(4'd0,  16'h0000);
        check_reg(4'd1,  16'h0000);
        check_reg(4'd3,  16'h000C);
        check_reg(4'd4,  16'h0000);
        check_reg(4'd5,  16'hF000);
        check_reg(4'd13, 16'h0001);
        check_reg(4'd15, 16'h0002);
        @(negedge clk);

        // MUL occupies S2 for DW cycles; the dependent ADD waits behind it.
        send(OP_MOV, 4'd1, 4'd0, 4'd0, 16'd300, 1'b1, 16'd300, 2, st);
        send(OP_MOV, 4'd2, 4'd0, 4'd0, 16'd300, 1'b1, 16'd300, 2, st);
        send(OP_MUL, 4'd7, 4'd1, 4'd2, 16'd0, 1'b1, 16'h5F90, 2 + DW - 1, st);
        check("mul_issue_stall", 32'(st), 32'd0);
        send(OP_ADD, 4'd8, 4'd7, 4'd1, 16'd0, 1'b1, 16'h60BC, 2 + DW - 1, st);
        check("add_after_mul_issue_stall", 32'(st), 32'd0);
        low = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (in_ready !== 1'b1) low++;
            @(negedge clk);
        end
        check("mul_in_ready_low_cycles", 32'(low), 32'd15);
        drain("mul");
        check_reg(4'd7, 16'h5F90);
        check_reg(4'd8, 16'h60BC);
        @(negedge clk);

        // Illegal opcode: bubble with no writeback, err becomes sticky.
        check("err_before_illegal", 32'(err), 32'd0);
        send(4'd14, 4'd3, 4'd1, 4'd2, 16'd0, 1'b0, 16'd0, 2, st);
        send(OP_NOP, 4'd3, 4'd1, 4'd2, 16'd0, 1'b0, 16'd0, 2, st);
        drain("illegal");
        check("err_after_illegal", 32'(err), 32'd1);
        check_reg(4'd3, 16'h000C);
        @(negedge clk);
        send(OP_ADDI, 4'd9, 4'd0, 4'd0, 16'd1, 1'b1, 16'h0001, 2, st);
        drain("after_illegal");
        check("err_sticky", 32'(err), 32'd1);
        @(negedge clk);

        // Reset while a MUL is in flight: nothing retires, file clears.
        send(OP_MUL, 4'd10, 4'd1, 4'd2, 16'd0, 1'b0, 16'd0, 2, st);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midmul_reset_in_ready", 32'(in_ready), 32'd0);
        check("midmul_reset_wb_valid", 32'(wb_valid), 32'd0);
        check("midmul_reset_busy", 32'(busy), 32'd0);
        check("midmul_reset_err", 32'(err), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("in_ready_after_release", 32'(in_ready), 32'd1);
        check("busy_after_release", 32'(busy), 32'd0);
        repeat (25) @(negedge clk);
        drain("reset_abort");
        for (int i = 0; i < NREG; i++) check_reg(RW'(i), '0);
        check("err_after_release", 32'(err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
